rob_ticket_scheduler: RTL and testbench

- Ticket allocator and completion-port arbiter in front of the reorder buffer.
- Hands out in-order ROB tickets at issue and stalls issue when the ROB is full.
- Arbitrates the single ROB write port among the ALU, MEM and MUL completion pipelines by ticket age (oldest first), and sequences store-buffer flush and exception-flush recovery.

---
 rtl/rob_ticket_scheduler.sv | 201 ++++++++++++++++++++
 tb/tb_rob_ticket_scheduler.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_ticket_scheduler.sv
// rob_ticket_scheduler: in-order ROB ticket allocator plus oldest-first
// arbiter for the single ROB write port, with store-buffer drain and
// exception-flush sequencing.
module rob_ticket_scheduler #(
    parameter int NUM_ENTRIES = 16,
    parameter int NUM_PORTS   = 3,
    localparam int TICKET_BITS = $clog2(NUM_ENTRIES),
    localparam int PORT_BITS   = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   alloc_req_in,
    output logic [TICKET_BITS-1:0] alloc_ticket_out,
    output logic                   alloc_stall_out,
    input  logic                   retire_in,
    output logic [TICKET_BITS-1:0] head_ticket_out,
    output logic [TICKET_BITS:0]   inflight_cnt_out,
    input  logic                   done_valid_in  [NUM_PORTS],
    input  logic [TICKET_BITS-1:0] done_ticket_in [NUM_PORTS],
    input  logic                   done_store_in  [NUM_PORTS],
    output logic                   done_wait_out  [NUM_PORTS],
    output logic                   rob_wr_valid_out,
    output logic [PORT_BITS-1:0]   rob_wr_port_out,
    output logic [TICKET_BITS-1:0] rob_wr_ticket_out,
    output logic                   stb_flush_out,
    input  logic                   flush_in,
    output logic                   err_out
);

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_STORE_HOLD = 2'd1,
        ST_FLUSH      = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [TICKET_BITS-1:0] head_q, head_d;
    logic [TICKET_BITS-1:0] tail_q, tail_d;
    logic [TICKET_BITS:0]   cnt_q, cnt_d;
    logic                   wr_valid_q, wr_valid_d;
    logic [PORT_BITS-1:0]   wr_port_q, wr_port_d;
    logic [TICKET_BITS-1:0] wr_ticket_q, wr_ticket_d;
    logic                   stb_flush_q, stb_flush_d;
    logic                   err_q, err_d;

    logic [TICKET_BITS-1:0] age_s [NUM_PORTS];
    logic                   req_s [NUM_PORTS];
    logic                   oor_any_s;
    logic                   win_found_s;
    logic [PORT_BITS-1:0]   win_idx_s;
    logic [TICKET_BITS-1:0] win_age_s;
    logic [TICKET_BITS-1:0] win_ticket_s;
    logic                   win_store_s;
    logic                   grant_s;
    logic                   alloc_stall_s;
    logic                   alloc_acc_s;
    logic                   retire_acc_s;

    assign alloc_ticket_out  = tail_q;
    assign alloc_stall_out   = alloc_stall_s;
    assign head_ticket_out   = head_q;
    assign inflight_cnt_out  = cnt_q;
    assign rob_wr_valid_out  = wr_valid_q;
    assign rob_wr_port_out   = wr_port_q;
    assign rob_wr_ticket_out = wr_ticket_q;
    assign stb_flush_out     = stb_flush_q;
    assign err_out           = err_q;

    // Age of each request relative to the head and oldest-first winner selection.
    always_comb begin
        oor_any_s    = 1'b0;
        win_found_s  = 1'b0;
        win_idx_s    = '0;
        win_age_s    = '0;
        win_ticket_s = '0;
        win_store_s  = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            // Modular subtraction keeps the age correct when tail < head.
            age_s[i] = done_ticket_in[i] - head_q;
            req_s[i] = done_valid_in[i] & ({1'b0, age_s[i]} < cnt_q);
            oor_any_s = oor_any_s | (done_valid_in[i] & ~req_s[i]);
            // Strict less-than lets the lowest index keep an age tie.
            if (req_s[i] && (!win_found_s || (age_s[i] < win_age_s))) begin
                win_found_s  = 1'b1;
                win_idx_s    = PORT_BITS'(i);
                win_age_s    = age_s[i];
                win_ticket_s = done_ticket_in[i];
                win_store_s  = done_store_in[i];
            end else begin
                win_found_s  = win_found_s;
            end
        end
    end

    // Grant, stall and acceptance qualifiers for this cycle.
    always_comb begin
        grant_s       = enable & ~flush_in & (state_q == ST_RUN) & win_found_s;
        alloc_stall_s = (cnt_q == (TICKET_BITS+1)'(NUM_ENTRIES)) | (state_q != ST_RUN) | ~enable;
        alloc_acc_s   = alloc_req_in & ~alloc_stall_s;
        retire_acc_s  = enable & retire_in & (cnt_q != '0);
    end

    // Per-port wait: losers hold their request, flushes drop everything.
    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (!enable) begin
                done_wait_out[i] = req_s[i];
            end else if (flush_in) begin
                done_wait_out[i] = 1'b0;
            end else begin
                case (state_q)
                    ST_RUN:        done_wait_out[i] = req_s[i] & ~(grant_s & (win_idx_s == PORT_BITS'(i)));
                    ST_STORE_HOLD: done_wait_out[i] = req_s[i];
                    ST_FLUSH:      done_wait_out[i] = 1'b0;
                    default:       done_wait_out[i] = 1'b0;
                endcase
            end
        end
    end

    // Next-state computation for pointers, sequencing state and write port.
    always_comb begin
        state_d     = state_q;
        head_d      = head_q;
        tail_d      = tail_q;
        cnt_d       = cnt_q;
        wr_valid_d  = 1'b0;
        wr_port_d   = wr_port_q;
        wr_ticket_d = wr_ticket_q;
        stb_flush_d = stb_flush_q;
        err_d       = err_q | (enable & oor_any_s);
        if (!enable) begin
            state_d = state_q;
        end else if (flush_in) begin
            state_d     = ST_FLUSH;
            head_d      = '0;
            tail_d      = '0;
            cnt_d       = '0;
            stb_flush_d = 1'b0;
        end else begin
            if (alloc_acc_s) begin
                tail_d = tail_q + TICKET_BITS'(1);
            end else begin
                tail_d = tail_q;
            end
            if (retire_acc_s) begin
                head_d = head_q + TICKET_BITS'(1);
            end else begin
                head_d = head_q;
            end
            case ({alloc_acc_s, retire_acc_s})
                2'b10:   cnt_d = cnt_q + (TICKET_BITS+1)'(1);
                2'b01:   cnt_d = cnt_q - (TICKET_BITS+1)'(1);
                default: cnt_d = cnt_q;
            endcase
            case (state_q)
                ST_RUN: begin
                    if (grant_s) begin
                        wr_valid_d  = 1'b1;
                        wr_port_d   = win_idx_s;
                        wr_ticket_d = win_ticket_s;
                        state_d     = win_store_s ? ST_STORE_HOLD : ST_RUN;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                ST_STORE_HOLD: state_d = ST_RUN;
                ST_FLUSH:      state_d = ST_RUN;
                default:       state_d = ST_RUN;
            endcase
            stb_flush_d = (state_d == ST_STORE_HOLD);
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_RUN;
            head_q      <= '0;
            tail_q      <= '0;
            cnt_q       <= '0;
            wr_valid_q  <= 1'b0;
            wr_port_q   <= '0;
            wr_ticket_q <= '0;
            stb_flush_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            cnt_q       <= cnt_d;
            wr_valid_q  <= wr_valid_d;
            wr_port_q   <= wr_port_d;
            wr_ticket_q <= wr_ticket_d;
            stb_flush_q <= stb_flush_d;
            err_q       <= err_d;
        end
    end

endmodule

// File: tb/tb_rob_ticket_scheduler.sv
// Self-checking bench for rob_ticket_scheduler: an integer-arithmetic model
// checked every cycle, plus literal expectations for the directed scenarios.
module tb_rob_ticket_scheduler;

    localparam int N  = 16;
    localparam int NP = 3;

    logic       clk = 1'b0;
    logic       reset, enable, alloc_req, retire, flush;
    logic [3:0] alloc_ticket, head_ticket, wr_ticket;
    logic       alloc_stall, wr_valid, stb_flush, err;
    logic [4:0] inflight;
    logic [1:0] wr_port;
    logic       dv [NP];
    logic [3:0] dt [NP];
    logic       ds [NP];
    logic       dw [NP];

    int n_pass  = 0;
    int n_total = 0;

    // Model state (plain integers).
    int m_head, m_tail, m_cnt;
    bit m_stb_due, m_just_flushed, m_err;
    bit m_wr_valid;
    int m_wr_port, m_wr_ticket;

    always #5 clk = ~clk;

    rob_ticket_scheduler #(.NUM_ENTRIES(N), .NUM_PORTS(NP)) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .alloc_req_in(alloc_req), .alloc_ticket_out(alloc_ticket),
        .alloc_stall_out(alloc_stall), .retire_in(retire),
        .head_ticket_out(head_ticket), .inflight_cnt_out(inflight),
        .done_valid_in(dv), .done_ticket_in(dt), .done_store_in(ds),
        .done_wait_out(dw), .rob_wr_valid_out(wr_valid),
        .rob_wr_port_out(wr_port), .rob_wr_ticket_out(wr_ticket),
        .stb_flush_out(stb_flush), .flush_in(flush), .err_out(err)
    );

    task automatic chk(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    endtask

    function automatic int m_age(input int p);
        return (int'(dt[p]) - m_head + N) % N;
    endfunction

    function automatic bit m_inrange(input int p);
        return dv[p] && (m_age(p) < m_cnt);
    endfunction

    function automatic int m_winner();
        int best = -1;
        for (int p = 0; p < NP; p++)
            if (m_inrange(p) && (best < 0 || m_age(p) < m_age(best))) best = p;
        return best;
    endfunction

    function automatic bit m_stall();
        return (m_cnt == N) || m_stb_due || m_just_flushed || !enable;
    endfunction

    function automatic bit m_can_grant();
        return enable && !flush && !m_stb_due && !m_just_flushed;
    endfunction

    function automatic bit m_wait(input int p);
        if (!m_inrange(p)) return 1'b0;
        if (!enable) return 1'b1;
        if (flush || m_just_flushed) return 1'b0;
        if (m_stb_due) return 1'b1;
        return p != m_winner();
    endfunction

    // Model update on each active edge from the inputs of the ending cycle.
    always @(posedge clk) begin
        int w;
        bit acc, ret, anyoor;
        if (reset) begin
            m_head <= 0; m_tail <= 0; m_cnt <= 0;
            m_stb_due <= 1'b0; m_just_flushed <= 1'b0; m_err <= 1'b0;
            m_wr_valid <= 1'b0; m_wr_port <= 0; m_wr_ticket <= 0;
        end else begin
            anyoor = 1'b0;
            for (int p = 0; p < NP; p++) if (dv[p] && !m_inrange(p)) anyoor = 1'b1;
            if (enable && anyoor) m_err <= 1'b1;
            if (!enable) begin
                m_wr_valid <= 1'b0;
            end else if (flush) begin
                m_head <= 0; m_tail <= 0; m_cnt <= 0;
                m_just_flushed <= 1'b1; m_stb_due <= 1'b0; m_wr_valid <= 1'b0;
            end else begin
                w   = m_can_grant() ? m_winner() : -1;
                acc = alloc_req && !m_stall();
                ret = retire && (m_cnt > 0);
                m_tail <= (m_tail + (acc ? 1 : 0)) % N;
                m_head <= (m_head + (ret ? 1 : 0)) % N;
                m_cnt  <= m_cnt + (acc ? 1 : 0) - (ret ? 1 : 0);
                m_wr_valid <= (w >= 0);
                if (w >= 0) begin
                    m_wr_port <= w;
                    m_wr_ticket <= int'(dt[w]);
                end
                m_stb_due <= (w >= 0) && ds[w];
                m_just_flushed <= 1'b0;
            end
        end
    end

    // Cycle-by-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (!reset) begin
            chk("alloc_ticket", alloc_ticket, m_tail);
            chk("alloc_stall", alloc_stall, m_stall());
            chk("head", head_ticket, m_head);
            chk("inflight", inflight, m_cnt);
            for (int p = 0; p < NP; p++) chk($sformatf("wait%0d", p), dw[p], m_wait(p));
            chk("wr_valid", wr_valid, m_wr_valid);
            if (m_wr_valid) begin
                chk("wr_port", wr_port, m_wr_port);
                chk("wr_ticket", wr_ticket, m_wr_ticket);
            end
            chk("stb_flush", stb_flush, m_stb_due);
            chk("err", err, m_err);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        alloc_req = 1'b0; retire = 1'b0; flush = 1'b0; enable = 1'b1;
        for (int p = 0; p < NP; p++) begin dv[p] = 1'b0; dt[p] = 4'd0; ds[p] = 1'b0; end
    endtask

    task automatic do_reset();
        clear_in();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        #1;
    endtask

    task automatic alloc_n(input int n);
        alloc_req = 1'b1;
        repeat (n) tick();
        alloc_req = 1'b0;
    endtask

    initial begin
        do_reset();
        // Reset values.
        chk("rst_head", head_ticket, 0);
        chk("rst_cnt", inflight, 0);
        chk("rst_wr_valid", wr_valid, 0);
        chk("rst_wr_port", wr_port, 0);
        chk("rst_wr_ticket", wr_ticket, 0);
        chk("rst_stb", stb_flush, 0);
        chk("rst_err", err, 0);

        // Fill: tickets 0..15, then a stalled 17th request with retire.
        for (int i = 0; i < N; i++) begin
            alloc_req = 1'b1; #1;
            chk("fill_ticket", alloc_ticket, i);
            chk("fill_stall", alloc_stall, 0);
            tick();
        end
        chk("full_cnt", inflight, 16);
        retire = 1'b1; #1;
        chk("full_stall", alloc_stall, 1);
        tick();
        retire = 1'b0; #1;
        chk("after_ret_stall", alloc_stall, 0);
        chk("after_ret_ticket", alloc_ticket, 0);
        tick();
        alloc_req = 1'b0;
        chk("refill_cnt", inflight, 16);
        chk("refill_head", head_ticket, 1);

        // Oldest-first arbitration, preceded by one disabled cycle.
        do_reset();
        alloc_n(4);
        dv[0] = 1'b1; dt[0] = 4'd3;
        dv[1] = 1'b1; dt[1] = 4'd1;
        dv[2] = 1'b1; dt[2] = 4'd2;
        enable = 1'b0; alloc_req = 1'b1; #1;
        chk("dis_wait1", dw[1], 1);
        chk("dis_stall", alloc_stall, 1);
        tick();
        alloc_req = 1'b0;
        chk("dis_wr_valid", wr_valid, 0);
        chk("dis_cnt", inflight, 4);
        enable = 1'b1; #1;
        chk("arb_wait0", dw[0], 1);
        chk("arb_wait1", dw[1], 0);
        chk("arb_wait2", dw[2], 1);
        tick();
        chk("arb_t1", wr_ticket, 1); chk("arb_p1", wr_port, 1); chk("arb_v1", wr_valid, 1);
        dv[1] = 1'b0;
        tick();
        chk("arb_t2", wr_ticket, 2); chk("arb_p2", wr_port, 2);
        dv[2] = 1'b0;
        tick();
        chk("arb_t3", wr_ticket, 3); chk("arb_p0", wr_port, 0);
        dv[0] = 1'b0;
        tick();
        chk("arb_idle", wr_valid, 0);

        // Wrap: head 14, tickets 14,15,0,1 in flight.
        do_reset();
        alloc_n(16);
        retire = 1'b1; repeat (14) tick(); retire = 1'b0;
        alloc_n(2);
        chk("wrap_head", head_ticket, 14);
        chk("wrap_cnt", inflight, 4);
        dv[0] = 1'b1; dt[0] = 4'd1;
        dv[1] = 1'b1; dt[1] = 4'd15; #1;
        chk("wrap_wait0", dw[0], 1);
        chk("wrap_wait1", dw[1], 0);
        tick();
        chk("wrap_port", wr_port, 1); chk("wrap_ticket", wr_ticket, 15);
        dv[1] = 1'b0;
        tick();
        chk("wrap_port2", wr_port, 0); chk("wrap_ticket2", wr_ticket, 1);
        dv[0] = 1'b0;
        tick();

        // Store: port 1 store wins (age 0) while port 0 (ticket 0, age 2) waits.
        dv[0] = 1'b1; dt[0] = 4'd0;
        dv[1] = 1'b1; dt[1] = 4'd14; ds[1] = 1'b1; #1;
        chk("st_wait0", dw[0], 1);
        chk("st_wait1", dw[1], 0);
        tick();
        chk("st_wr_port", wr_port, 1); chk("st_wr_ticket", wr_ticket, 14);
        chk("st_stb", stb_flush, 1);
        dv[1] = 1'b0; ds[1] = 1'b0; #1;
        chk("st_hold_wait0", dw[0], 1);
        tick();
        chk("st_no_write", wr_valid, 0);
        chk("st_stb_off", stb_flush, 0);
        tick();
        chk("st_p0_valid", wr_valid, 1);
        chk("st_p0_port", wr_port, 0); chk("st_p0_ticket", wr_ticket, 0);
        dv[0] = 1'b0;
        tick();

        // Flush with pending requests and an issue request in the same cycle.
        do_reset();
        alloc_n(5);
        dv[0] = 1'b1; dt[0] = 4'd1;
        dv[1] = 1'b1; dt[1] = 4'd2;
        flush = 1'b1; alloc_req = 1'b1; #1;
        chk("fl_wait0", dw[0], 0);
        chk("fl_wait1", dw[1], 0);
        tick();
        flush = 1'b0; dv[0] = 1'b0; dv[1] = 1'b0;
        chk("fl_head", head_ticket, 0); chk("fl_cnt", inflight, 0);
        chk("fl_tail", alloc_ticket, 0); chk("fl_stall", alloc_stall, 1);
        chk("fl_wr_valid", wr_valid, 0);
        tick();
        chk("fl_post_stall", alloc_stall, 0);
        chk("fl_post_ticket", alloc_ticket, 0);
        tick();
        alloc_req = 1'b0;
        chk("fl_post_cnt", inflight, 1);

        // Out-of-range ticket sets sticky err.
        do_reset();
        alloc_n(2);
        dv[2] = 1'b1; dt[2] = 4'd7; #1;
        chk("oor_wait2", dw[2], 0);
        tick();
        dv[2] = 1'b0;
        chk("oor_no_write", wr_valid, 0);
        chk("oor_err", err, 1);
        retire = 1'b1; repeat (3) tick(); retire = 1'b0;
        chk("oor_err_sticky", err, 1);
        do_reset();
        chk("oor_err_cleared", err, 0);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
